uart_line_rx: RTL and testbench
===============================

Name: uart_line_rx

Overview:
- Simulation/debug UART receiver that deserializes an asynchronous 8N1 serial line (e.g. the SoC `serial_tx` pin) into a byte stream.
- Output is a byte plus a single-cycle valid strobe, in the exact format consumed by the downstream console-print stage (`uart_data[7:0]` / `uart_data_valid`).
- Sits directly upstream of the print stage in the top-level bench. It lets the physical UART pin be logged alongside the sim-only byte taps.

Parameters:
- CLK_DIV, 16: clk cycles per serial bit. Legal range is 4..65535, even values only.
- STOP_CHECK, 1: 1 = a low stop bit is a framing error. 0 = the stop bit is not checked and the byte is always delivered.

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- rx  input  1  asynchronous serial line, idle high
- rx_en  input  1  receiver enable; low forces IDLE
- uart_data  output  8  last received byte
- uart_data_valid  output  1  one-cycle strobe, new byte on uart_data
- frame_err  output  1  one-cycle strobe, stop bit sampled low
- line_break  output  1  one-cycle strobe, all-zero frame with low stop bit
- busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (resetn low, asynchronous):
  - uart_data = 0x00; uart_data_valid, frame_err, line_break, busy = 0.
  - FSM = IDLE.
  - Both synchronizer flops = 1 (idle line), so no false start on reset release.
- Input synchronization:
  - rx passes through a 2-flop synchronizer; rx_s is the second flop's output.
  - All sampling below uses rx_s.
- Bit counter:
  - cnt is $clog2(CLK_DIV) bits wide, down-counting.
  - A "tick" is cnt==0; the counter reloads CLK_DIV-1 on each tick.
  - bitidx is 3 bits.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE:
    - If rx_en & ~rx_s at clock edge t0: go to START and load cnt = CLK_DIV/2-1.
  - START:
    - At the tick (edge t0+CLK_DIV/2), sample rx_s.
    - rx_s = 1: false start (glitch). Go to IDLE; no strobe.
    - rx_s = 0: go to DATA, cnt = CLK_DIV-1, bitidx = 0.
  - DATA:
    - At each tick, shift rx_s into shreg MSB and shift right (LSB-first on the line).
    - Data bit i is sampled at edge t0+CLK_DIV/2+(i+1)*CLK_DIV.
    - After bit 7, go to STOP.
  - STOP:
    - Tick at edge t0+CLK_DIV/2+9*CLK_DIV.
    - If rx_s=1 or STOP_CHECK=0: uart_data <= shreg, uart_data_valid=1 for exactly the following cycle, go to IDLE.
    - Else: frame_err=1 for one cycle. Additionally line_break=1 the same cycle if shreg==0x00. uart_data is unchanged, no valid strobe. Go to WAIT_HIGH.
  - WAIT_HIGH:
    - Stay until rx_s==1, then go to IDLE. This prevents re-triggering on a held-low break.
- Latency:
  - uart_data_valid is high in the cycle after edge t0+CLK_DIV/2+9*CLK_DIV.
  - With CLK_DIV=16, that is after edge t0+152.
- Back-to-back frames:
  - Returning to IDLE at the stop tick lets a start edge one cycle later be accepted.
  - Baud mismatch tolerance is ±4% with no inter-frame gap.
- rx_en:
  - rx_en deasserted in any state aborts to IDLE next edge, with no strobes; the partial byte is discarded.
  - uart_data keeps its previous value.
- Output stability:
  - uart_data only changes on the valid-strobe cycle's update.
  - Strobes are mutually exclusive except that line_break implies frame_err.
- Reset mid-frame: outputs clear immediately. After release the receiver resyncs on the next falling edge; the remainder of the aborted frame may produce a frame_err.

Test Plan:
1. CLK_DIV=16: drive 0x41 in 8N1 at 16 clk/bit -> uart_data_valid high exactly one cycle, 152 edges after t0, with uart_data=0x41; frame_err=0.
2. Drive "Hi\n" (0x48,0x69,0x0A) back-to-back with zero idle bits -> three valid strobes with bytes in order; feeding uart_print prints "[kernel] Hi".
3. 3-cycle low glitch on rx from idle -> START samples high, returns to IDLE; no strobes; busy high for at most CLK_DIV/2+1 cycles.
4. Frame 0x55 with stop bit low -> frame_err one cycle, no valid, uart_data keeps its prior value. Holding rx low for 40 bits -> line_break+frame_err once, then the FSM stays in WAIT_HIGH until rx rises.
5. Deassert rx_en at bit 4 of a frame -> busy falls next cycle, no strobes. Re-enable and send 0xA5 -> valid with 0xA5.
6. Assert resetn=0 mid-frame (bit 3), release, then send 0x7E -> all outputs 0 during reset; 0x7E is received correctly afterwards.

Source files
------------

// File: rtl/uart_line_rx.sv
// uart_line_rx: 8N1 serial receiver producing a byte plus one-cycle valid/error strobes
module uart_line_rx #(
   parameter int CLK_DIV    = 16,
   parameter bit STOP_CHECK = 1'b1
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       rx,
   input  logic       rx_en,
   output logic [7:0] uart_data,
   output logic       uart_data_valid,
   output logic       frame_err,
   output logic       line_break,
   output logic       busy
);
   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] HALF   = CW'(CLK_DIV / 2 - 1);
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
   state_t        state_q, state_d;
   logic [1:0]    sync_q, sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bitidx_q, bitidx_d;
   logic [7:0]    shreg_q, shreg_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;
   logic          brk_q, brk_d;
   logic          rx_s, tick;
   assign rx_s            = sync_q[1];
   assign tick            = cnt_q == '0;
   assign sync_d          = {sync_q[0], rx};
   assign uart_data       = data_q;
   assign uart_data_valid = valid_q;
   assign frame_err       = ferr_q;
   assign line_break      = brk_q;
   assign busy            = state_q != IDLE;
   // next-state: bit timing, shifting, and strobe generation
   always_comb begin
      state_d  = state_q;
      cnt_d    = tick ? RELOAD : cnt_q - 1'b1;
      bitidx_d = bitidx_q;
      shreg_d  = shreg_q;
      data_d   = data_q;
      valid_d  = 1'b0;
      ferr_d   = 1'b0;
      brk_d    = 1'b0;
      if (!rx_en) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (!rx_s) begin
               state_d = START;
               cnt_d   = HALF;
            end
            START: if (tick) begin
               state_d  = rx_s ? IDLE : DATA;
               bitidx_d = 3'd0;
            end
            DATA: if (tick) begin
               shreg_d  = {rx_s, shreg_q[7:1]};
               bitidx_d = bitidx_q + 3'd1;
               if (bitidx_q == 3'd7) state_d = STOP;
            end
            STOP: if (tick) begin
               if (rx_s || !STOP_CHECK) begin
                  data_d  = shreg_q;
                  valid_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  brk_d   = shreg_q == 8'h00;
                  state_d = WAIT_HIGH;
               end
            end
            WAIT_HIGH: if (rx_s) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end
   // state and output registers; synchronizer resets to idle-high to avoid a false start
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         sync_q   <= 2'b11;
         cnt_q    <= '0;
         bitidx_q <= 3'd0;
         shreg_q  <= 8'h00;
         data_q   <= 8'h00;
         valid_q  <= 1'b0;
         ferr_q   <= 1'b0;
         brk_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sync_q   <= sync_d;
         cnt_q    <= cnt_d;
         bitidx_q <= bitidx_d;
         shreg_q  <= shreg_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         ferr_q   <= ferr_d;
         brk_q    <= brk_d;
      end
   end
endmodule

// File: tb/tb_uart_line_rx.sv
// tb_uart_line_rx: directed frames with a queue-based strobe scoreboard
module tb_uart_line_rx;
   localparam int DIV = 16;
   localparam int LAT = 3 + DIV / 2 + 9 * DIV;
   logic       clk, resetn, rx, rx_en;
   logic [7:0] uart_data;
   logic       uart_data_valid, frame_err, line_break, busy;
   int tests = 0, fails = 0, cyc = 0;
   typedef struct {int kind; int data; int cyc;} exp_t;
   exp_t q[$];
   uart_line_rx #(.CLK_DIV(DIV), .STOP_CHECK(1'b1)) dut (
      .clk(clk), .resetn(resetn), .rx(rx), .rx_en(rx_en),
      .uart_data(uart_data), .uart_data_valid(uart_data_valid),
      .frame_err(frame_err), .line_break(line_break), .busy(busy)
   );
   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end
   always @(posedge clk) cyc <= cyc + 1;
   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   // monitor: kind encodes {line_break, frame_err, valid}
   exp_t e;
   int   got;
   always @(negedge clk) begin
      if (resetn && (uart_data_valid || frame_err || line_break)) begin
         got = {29'd0, line_break, frame_err, uart_data_valid};
         if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_strobe: got kind %0d data %02h expected none", got, uart_data);
         end else begin
            e = q.pop_front();
            check("strobe_kind", got, e.kind);
            if (e.kind == 1) check("strobe_data", uart_data, e.data);
            check("strobe_cycle", cyc, e.cyc);
         end
      end
   end
   task automatic send_bit(input logic v);
      rx = v;
      repeat (DIV) @(posedge clk);
      #1;
   endtask
   task automatic send_frame(input logic [7:0] b, input logic stop_v);
      exp_t x;
      x.kind = stop_v ? 1 : (b == 8'h00 ? 6 : 2);
      x.data = b;
      x.cyc  = cyc + LAT;
      q.push_back(x);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(stop_v);
   endtask
   task automatic drain(input string name);
      int n = 0;
      while (q.size() != 0 && n < 400) begin
         @(posedge clk);
         n++;
      end
      #1;
      check({name, "_pending"}, q.size(), 0);
      q.delete();
   endtask
   int nb;
   initial begin
      resetn = 0; rx = 1; rx_en = 1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_data", uart_data, 0);
      check("rst_valid", uart_data_valid, 0);
      check("rst_ferr", frame_err, 0);
      check("rst_brk", line_break, 0);
      check("rst_busy", busy, 0);
      resetn = 1;
      repeat (5) @(posedge clk);
      #1;
      // single byte with latency check
      send_frame(8'h41, 1'b1);
      send_bit(1'b1);
      drain("t1");
      check("t1_hold", uart_data, 8'h41);
      // back-to-back frames, no idle bits
      send_frame(8'h48, 1'b1);
      send_frame(8'h69, 1'b1);
      send_frame(8'h0A, 1'b1);
      send_bit(1'b1);
      drain("t2");
      // short low glitch: false start, no strobe
      nb = 0;
      rx = 0;
      repeat (3) @(posedge clk);
      #1;
      rx = 1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (busy) nb++;
      end
      check("t3_busy_seen", int'(nb > 0), 1);
      check("t3_busy_bound", int'(nb <= DIV / 2 + 1), 1);
      @(posedge clk);
      #1;
      drain("t3");
      // framing error keeps old data
      send_frame(8'h55, 1'b0);
      rx = 1;
      repeat (DIV) @(posedge clk);
      #1;
      drain("t4a");
      check("t4_data_kept", uart_data, 8'h0A);
      // held-low break: one frame_err+line_break, then wait for high
      begin
         exp_t x;
         x.kind = 6; x.data = 0; x.cyc = cyc + LAT;
         q.push_back(x);
      end
      rx = 0;
      repeat (40 * DIV) @(posedge clk);
      #1;
      check("t4_wait_high_busy", busy, 1);
      check("t4_brk_seen", q.size(), 0);
      rx = 1;
      repeat (4) @(posedge clk);
      #1;
      check("t4_idle_after_high", busy, 0);
      check("t4_data_kept2", uart_data, 8'h0A);
      // rx_en abort at bit 4
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      rx = 1'b0;
      repeat (DIV / 2) @(posedge clk);
      #1;
      check("t5_busy_before", busy, 1);
      rx_en = 0;
      @(posedge clk);
      #1;
      check("t5_busy_after", busy, 0);
      repeat (DIV / 2 - 1) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) send_bit(1'b0);
      send_bit(1'b1);
      check("t5_data_kept", uart_data, 8'h0A);
      rx_en = 1;
      repeat (4) @(posedge clk);
      #1;
      send_frame(8'hA5, 1'b1);
      send_bit(1'b1);
      drain("t5");
      // reset in the middle of bit 3
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      repeat (DIV / 2) @(posedge clk);
      #1;
      resetn = 0;
      #1;
      check("t6_rst_data", uart_data, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_strobes", {uart_data_valid, frame_err, line_break}, 0);
      rx = 1;
      repeat (3) @(posedge clk);
      #1;
      resetn = 1;
      repeat (4) @(posedge clk);
      #1;
      send_frame(8'h7E, 1'b1);
      send_bit(1'b1);
      drain("t6");
      check("t6_final_data", uart_data, 8'h7E);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
